thresholding_obuf: RTL and testbench



---
 rtl/thresholding_pkg.sv | 22 ++
 rtl/thresholding_fifo.sv | 50 +++++
 rtl/thresholding_obuf.sv | 76 +++++++
 tb/tb_thresholding_obuf.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/thresholding_pkg.sv
// Shared width helpers for the thresholding output stage.
// Result width is the count plus a sign bit; the stream width rounds it up to bytes.
package thresholding_pkg;

   function automatic int o_bits(input int n);
      return n + 1;
   endfunction

   function automatic int d_bits(input int n);
      return 8 * ((n + 1 + 7) / 8);
   endfunction

   // Storage width of one queued entry: {last, signed result}.
   function automatic int entry_bits(input int n);
      return o_bits(n) + 1;
   endfunction

   function automatic int c_bits(input int c);
      return (c < 2) ? 1 : $clog2(c);
   endfunction

endpackage

// File: rtl/thresholding_fifo.sv
// Generic DEPTH x W queue with registered storage; DEPTH need not be a power of two.
module thresholding_fifo #(
   parameter  int DEPTH = 2,
   parameter  int W     = 8,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/thresholding_obuf.sv
// Output stage of the thresholding pipeline: bias, buffer, AXI-Stream out.
// en doubles as upstream ready and freezes the pipeline while the queue is full.
module thresholding_obuf
   import thresholding_pkg::*;
#(
   parameter  int N      = 4,
   parameter  int C      = 1,
   parameter  int BIAS   = 0,
   parameter  int DEPTH  = 2,
   localparam int C_BITS = c_bits(C),
   localparam int O_BITS = o_bits(N),
   localparam int D_BITS = d_bits(N)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              en,
   output logic              s_ready,
   input  logic              ivld,
   input  logic [C_BITS-1:0] icnl,
   input  logic [N-1:0]      idat,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [D_BITS-1:0] m_tdata,
   output logic              m_tlast
);

   localparam int EW = entry_bits(N);
   localparam int CW = $clog2(DEPTH + 1);

   if (BIAS > 0 || BIAS < -(2 ** N)) begin : g_bias_chk
      $error("thresholding_obuf: BIAS out of range");
   end
   if (DEPTH < 2) begin : g_depth_chk
      $error("thresholding_obuf: DEPTH must be at least 2");
   end

   typedef struct packed {
      logic                     last;
      logic signed [O_BITS-1:0] res;
   } entry_t;

   entry_t        wr_e, rd_e;
   logic [EW-1:0] rdata;
   logic [CW-1:0] count;
   logic          full, empty, push, pop;

   // en depends only on the registered count, never on m_tready.
   assign en       = (count < CW'(DEPTH));
   assign s_ready  = en;
   assign push     = ivld && !full;
   assign m_tvalid = !empty;
   assign pop      = m_tvalid && m_tready;

   always_comb begin
      wr_e      = '0;
      wr_e.res  = O_BITS'($signed({1'b0, idat}) + BIAS);
      wr_e.last = (C == 1) ? 1'b1 : (icnl == C_BITS'(C - 1));
   end

   thresholding_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wr_e),
      .pop   (pop),
      .rdata (rdata),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign rd_e    = rdata;
   assign m_tdata = D_BITS'(rd_e.res);
   assign m_tlast = rd_e.last;

endmodule

// File: tb/tb_thresholding_obuf.sv
// Drives three configurations of the output stage with shared stimulus and
// checks each against a queue model derived from the stream rules.
module tb_thresholding_obuf;

   localparam int DEP [3] = '{2, 2, 3};
   localparam int BIA [3] = '{-8, 0, -16};
   localparam int CC  [3] = '{3, 1, 3};

   logic       clk = 1'b0;
   logic       rst;
   logic       ivld, m_tready;
   logic [1:0] icnl;
   logic [3:0] idat;
   logic [2:0] en_w, srdy_w, tv_w, tl_w;
   logic [7:0] td_w [3];

   always #5 clk = ~clk;

   thresholding_obuf #(.N(4), .C(3), .BIAS(-8), .DEPTH(2)) u0 (
      .clk(clk), .rst(rst), .en(en_w[0]), .s_ready(srdy_w[0]), .ivld(ivld),
      .icnl(icnl), .idat(idat), .m_tvalid(tv_w[0]), .m_tready(m_tready),
      .m_tdata(td_w[0]), .m_tlast(tl_w[0]));

   thresholding_obuf #(.N(4), .C(1), .BIAS(0), .DEPTH(2)) u1 (
      .clk(clk), .rst(rst), .en(en_w[1]), .s_ready(srdy_w[1]), .ivld(ivld),
      .icnl(icnl[0]), .idat(idat), .m_tvalid(tv_w[1]), .m_tready(m_tready),
      .m_tdata(td_w[1]), .m_tlast(tl_w[1]));

   thresholding_obuf #(.N(4), .C(3), .BIAS(-16), .DEPTH(3)) u2 (
      .clk(clk), .rst(rst), .en(en_w[2]), .s_ready(srdy_w[2]), .ivld(ivld),
      .icnl(icnl), .idat(idat), .m_tvalid(tv_w[2]), .m_tready(m_tready),
      .m_tdata(td_w[2]), .m_tlast(tl_w[2]));

   // Model: one ring of expected entries per DUT, encoded {last, byte}.
   int mq [3][32];
   int hd [3];
   int cnt [3];
   int nerr, nchk;
   int lg_d [64];
   int lg_l [64];
   int nlg, npush0;

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s dut%0d: observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask

   function automatic int expv(input int d);
      int r, l;
      r = int'(idat) + BIA[d];
      l = (CC[d] == 1) ? 1 : ((int'(icnl) == CC[d] - 1) ? 1 : 0);
      return (r & 255) | (l << 8);
   endfunction

   // Check outputs at the falling edge, then advance the model to the next rising edge.
   task automatic cycle();
      int   e;
      logic xen;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         xen = (cnt[d] < DEP[d]);
         chk("en", d, en_w[d], xen);
         chk("s_ready", d, srdy_w[d], xen);
         chk("tvalid", d, tv_w[d], cnt[d] != 0);
         if (cnt[d] != 0) begin
            e = mq[d][hd[d] % 32];
            chk("tdata", d, td_w[d], e & 255);
            chk("tlast", d, tl_w[d], (e >> 8) & 1);
            if (m_tready) begin
               if (d == 0 && nlg < 64) begin
                  lg_d[nlg] = e & 255;
                  lg_l[nlg] = (e >> 8) & 1;
                  nlg++;
               end
               hd[d]++;
               cnt[d]--;
            end
         end
         if (ivld && xen) begin
            mq[d][(hd[d] + cnt[d]) % 32] = expv(d);
            cnt[d]++;
            if (d == 0) npush0++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic mid_reset();
      rst  = 1'b1;
      ivld = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("rst_tvalid", d, tv_w[d], 0);
         chk("rst_en", d, en_w[d], 1);
         cnt[d] = 0;
         hd[d]  = 0;
      end
      #2 rst = 1'b0;
   endtask

   initial begin
      int bv [3];
      int ch [4];
      bv = '{0, 8, 15};
      ch = '{0, 1, 2, 0};
      nerr = 0; nchk = 0; nlg = 0; npush0 = 0;
      for (int d = 0; d < 3; d++) begin cnt[d] = 0; hd[d] = 0; end
      rst = 1'b1; ivld = 1'b0; m_tready = 1'b0; idat = '0; icnl = '0;

      #2;
      for (int d = 0; d < 3; d++) begin
         chk("reset_tvalid", d, tv_w[d], 0);
         chk("reset_en", d, en_w[d], 1);
      end
      #10 rst = 1'b0;
      @(posedge clk);
      #1;

      // Bias and sign extension, one beat per cycle after one cycle of latency.
      m_tready = 1'b1; nlg = 0;
      for (int i = 0; i < 3; i++) begin
         ivld = 1'b1; idat = 4'(bv[i]); icnl = 2'd0;
         cycle();
      end
      ivld = 1'b0;
      repeat (3) cycle();
      chk("bias_beats", 0, nlg, 3);
      chk("bias_0", 0, lg_d[0], 32'hF8);
      chk("bias_8", 0, lg_d[1], 32'h00);
      chk("bias_15", 0, lg_d[2], 32'h07);

      // tlast on channel C-1 only.
      nlg = 0;
      for (int i = 0; i < 4; i++) begin
         ivld = 1'b1; idat = 4'(i + 3); icnl = 2'(ch[i]);
         cycle();
      end
      ivld = 1'b0;
      repeat (3) cycle();
      chk("tlast_0", 0, lg_l[0], 0);
      chk("tlast_1", 0, lg_l[1], 0);
      chk("tlast_2", 0, lg_l[2], 1);
      chk("tlast_3", 0, lg_l[3], 0);

      // Backpressure: queue fills to DEPTH, en drops, then drains in order.
      m_tready = 1'b0; npush0 = 0;
      for (int i = 0; i < 5; i++) begin
         ivld = 1'b1; idat = 4'(i * 3 + 1); icnl = 2'(i % 3);
         cycle();
      end
      chk("bp_pushes", 0, npush0, 2);
      chk("bp_en_low", 0, en_w[0], 0);
      m_tready = 1'b1;
      cycle();
      ivld = 1'b0;
      repeat (4) cycle();

      // Reset while entries are queued.
      m_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ivld = 1'b1; idat = 4'(i + 9); icnl = 2'(i);
         cycle();
      end
      mid_reset();
      repeat (2) cycle();

      // Sustained throughput with ready held high.
      m_tready = 1'b1; nlg = 0;
      for (int i = 0; i < 20; i++) begin
         ivld = 1'b1; idat = 4'($urandom); icnl = 2'($urandom_range(0, 2));
         cycle();
      end
      ivld = 1'b0;
      cycle();
      chk("tput_beats", 0, nlg, 20);
      repeat (2) cycle();

      // Random traffic on both sides.
      for (int i = 0; i < 1000; i++) begin
         ivld = 1'($urandom_range(0, 1));
         m_tready = 1'($urandom_range(0, 1));
         idat = 4'($urandom);
         icnl = 2'($urandom_range(0, 2));
         cycle();
      end
      ivld = 1'b0; m_tready = 1'b1;
      repeat (5) cycle();
      for (int d = 0; d < 3; d++) chk("drained", d, tv_w[d], 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
